// File: rtl/serial_parity_framer_pkg.sv
// Shared definitions for the serial parity framer: FSM states, mode and
// parity-sense constants, and the frame bit-index width.
package parity_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  localparam int unsigned MODE_GEN   = 0;
  localparam int unsigned MODE_CHECK = 1;

  localparam int unsigned PAR_EVEN = 0;
  localparam int unsigned PAR_ODD  = 1;

  // Holds 0..255, enough for the longest frame (255 data bits + parity).
  localparam int unsigned IDX_W = 8;

endpackage

// File: rtl/serial_parity_framer_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk    in   clock
//   reset  in   synchronous active-high reset (highest priority)
//   clear  in   synchronous clear, wins over inc
//   inc    in   count up by one, sticking at all-ones
//   count  out  W-bit registered count
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX = {W{1'b1}};

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/serial_parity_framer.sv
// Serial parity framer: groups qualified input bits into frames and either
// generates the parity bit (GEN) or flags a bad trailing parity bit (CHECK).
//   clk          in   clock
//   reset        in   synchronous active-high reset
//   ip           in   serial data bit
//   ip_valid     in   qualifies ip; state holds when low
//   clear        in   synchronous clear of both statistics counters
//   p            out  GEN: parity bit; CHECK: mismatch flag (held between pulses)
//   p_valid      out  one-cycle pulse, one cycle after the last bit of a frame
//   busy         out  a partial frame is held
//   frame_count  out  completed frames, saturating
//   err_count    out  CHECK: frames with mismatch, saturating; GEN: always 0
module serial_parity_framer
  import parity_pkg::*;
#(
  parameter int unsigned DATA_BITS = 3,
  parameter int unsigned ODD       = 1,
  parameter int unsigned CHECK     = 0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ip,
  input  logic             ip_valid,
  input  logic             clear,
  output logic             p,
  output logic             p_valid,
  output logic             busy,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned FRAME_LEN = DATA_BITS + CHECK;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic IS_CHECK = (CHECK == MODE_CHECK);
  localparam logic ODD_BIT  = (ODD == PAR_ODD);

  state_t           state;
  logic [IDX_W-1:0] bit_idx;
  logic             acc;

  logic frame_done_c;
  logic par_x_c;
  logic err_inc_c;

  // A qualified bit at the last index closes the frame this cycle.
  assign frame_done_c = ip_valid && (bit_idx == LAST_IDX);
  // Same expression serves both modes: GEN parity bit or CHECK mismatch flag.
  assign par_x_c      = acc ^ ip ^ ODD_BIT;
  assign err_inc_c    = IS_CHECK && frame_done_c && par_x_c;

  // Frame FSM, bit index / running XOR and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      bit_idx <= '0;
      acc     <= 1'b0;
      p       <= 1'b0;
      p_valid <= 1'b0;
      busy    <= 1'b0;
    end else begin
      p_valid <= 1'b0;
      if (ip_valid) begin
        if (bit_idx == LAST_IDX) begin
          state   <= ST_IDLE;
          bit_idx <= '0;
          acc     <= 1'b0;
          p       <= par_x_c;
          p_valid <= 1'b1;
          busy    <= 1'b0;
        end else begin
          if (state == ST_IDLE) begin
            state <= ST_COLLECT;
          end
          bit_idx <= bit_idx + IDX_W'(1);
          acc     <= acc ^ ip;
          busy    <= 1'b1;
        end
      end
    end
  end

  // Counters step on the same edge that raises p_valid.
  sat_counter #(.W(CNT_W)) u_frame_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   (frame_done_c),
    .count (frame_count)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   (err_inc_c),
    .count (err_count)
  );

endmodule

// File: tb/tb_serial_parity_framer.sv
// Bench for serial_parity_framer: four parameterisations side by side,
// a directed vector table, hand sequences and randomized traffic against
// a frame-level reference model.
module tb_serial_parity_framer;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  logic ip  [N];
  logic ipv [N];
  logic clr [N];
  logic p   [N];
  logic pv  [N];
  logic bsy [N];
  logic [15:0] fc [N];
  logic [15:0] ec [N];
  logic [1:0]  fc2, ec2;

  int db [N];
  int odd [N];
  int chkm [N];
  int cw [N];

  int errors = 0;
  int checks = 0;

  // reference model state per DUT
  int m_n [N];
  int m_ones [N];
  int m_fc [N];
  int m_ec [N];
  bit m_p [N];
  bit m_pv [N];
  bit m_busy [N];

  always #5 clk = ~clk;

  serial_parity_framer #(.DATA_BITS(3), .ODD(1), .CHECK(0), .CNT_W(16)) u_gen3 (
    .clk(clk), .reset(reset), .ip(ip[0]), .ip_valid(ipv[0]), .clear(clr[0]),
    .p(p[0]), .p_valid(pv[0]), .busy(bsy[0]), .frame_count(fc[0]), .err_count(ec[0]));

  serial_parity_framer #(.DATA_BITS(3), .ODD(0), .CHECK(1), .CNT_W(16)) u_chk3 (
    .clk(clk), .reset(reset), .ip(ip[1]), .ip_valid(ipv[1]), .clear(clr[1]),
    .p(p[1]), .p_valid(pv[1]), .busy(bsy[1]), .frame_count(fc[1]), .err_count(ec[1]));

  serial_parity_framer #(.DATA_BITS(4), .ODD(1), .CHECK(0), .CNT_W(2)) u_gen4 (
    .clk(clk), .reset(reset), .ip(ip[2]), .ip_valid(ipv[2]), .clear(clr[2]),
    .p(p[2]), .p_valid(pv[2]), .busy(bsy[2]), .frame_count(fc2), .err_count(ec2));

  serial_parity_framer #(.DATA_BITS(1), .ODD(1), .CHECK(0), .CNT_W(16)) u_gen1 (
    .clk(clk), .reset(reset), .ip(ip[3]), .ip_valid(ipv[3]), .clear(clr[3]),
    .p(p[3]), .p_valid(pv[3]), .busy(bsy[3]), .frame_count(fc[3]), .err_count(ec[3]));

  assign fc[2] = {14'd0, fc2};
  assign ec[2] = {14'd0, ec2};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: count ones over a frame; the result is 1 whenever the
  // ones total disagrees with the selected parity sense.
  function automatic void model_edge(int d);
    int flen;
    int maxc;
    bit done;
    bit odd_total;
    flen = db[d] + chkm[d];
    maxc = (1 << cw[d]) - 1;
    done = 1'b0;
    if (reset === 1'b1) begin
      m_n[d] = 0; m_ones[d] = 0; m_fc[d] = 0; m_ec[d] = 0;
      m_p[d] = 1'b0; m_pv[d] = 1'b0; m_busy[d] = 1'b0;
      return;
    end
    m_pv[d] = 1'b0;
    if (ipv[d] === 1'b1) begin
      m_ones[d] += (ip[d] === 1'b1) ? 1 : 0;
      m_n[d]++;
      if (m_n[d] == flen) begin
        odd_total = (m_ones[d] % 2) == 1;
        m_p[d]  = (odd_total != (odd[d] == 1));
        m_pv[d] = 1'b1;
        m_n[d] = 0;
        m_ones[d] = 0;
        done = 1'b1;
      end
    end
    m_busy[d] = (m_n[d] != 0);
    if (clr[d] === 1'b1) begin
      m_fc[d] = 0;
      m_ec[d] = 0;
    end else if (done) begin
      if (m_fc[d] < maxc) m_fc[d]++;
      if (chkm[d] == 1 && m_p[d] && m_ec[d] < maxc) m_ec[d]++;
    end
  endfunction

  // One clock: advance the model, then compare every DUT against it.
  task automatic step();
    @(posedge clk);
    for (int d = 0; d < N; d++) model_edge(d);
    #1;
    for (int d = 0; d < N; d++) begin
      chk($sformatf("m_p%0d", d), 32'(p[d]), 32'(m_p[d]));
      chk($sformatf("m_pv%0d", d), 32'(pv[d]), 32'(m_pv[d]));
      chk($sformatf("m_busy%0d", d), 32'(bsy[d]), 32'(m_busy[d]));
      chk($sformatf("m_fc%0d", d), 32'(fc[d]), 32'(m_fc[d]));
      chk($sformatf("m_ec%0d", d), 32'(ec[d]), 32'(m_ec[d]));
    end
  endtask

  task automatic idle_all();
    for (int d = 0; d < N; d++) begin
      ip[d] = 1'b0; ipv[d] = 1'b0; clr[d] = 1'b0;
    end
  endtask

  task automatic send(input int d, input bit b);
    ipv[d] = 1'b1;
    ip[d]  = b;
    step();
    ipv[d] = 1'b0;
    ip[d]  = 1'b0;
  endtask

  typedef struct {
    bit rst; bit v; bit b;
    bit ep; bit epv; bit ebusy; int efc;
  } vec_t;

  vec_t tv [15];

  initial begin
    db   = '{3, 3, 4, 1};
    odd  = '{1, 0, 1, 1};
    chkm = '{0, 1, 0, 0};
    cw   = '{16, 16, 2, 16};
    idle_all();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // GEN/odd/3 bits: two back-to-back frames, then reset mid-frame.
    tv[0]  = '{1, 0, 0,  0, 0, 0, 0};
    tv[1]  = '{0, 1, 1,  0, 0, 1, 0};
    tv[2]  = '{0, 1, 0,  0, 0, 1, 0};
    tv[3]  = '{0, 1, 0,  0, 1, 0, 1};
    tv[4]  = '{0, 1, 1,  0, 0, 1, 1};
    tv[5]  = '{0, 1, 1,  0, 0, 1, 1};
    tv[6]  = '{0, 1, 0,  1, 1, 0, 2};
    tv[7]  = '{0, 0, 0,  1, 0, 0, 2};
    tv[8]  = '{0, 1, 1,  1, 0, 1, 2};
    tv[9]  = '{0, 1, 1,  1, 0, 1, 2};
    tv[10] = '{1, 0, 0,  0, 0, 0, 0};
    tv[11] = '{0, 1, 1,  0, 0, 1, 0};
    tv[12] = '{0, 1, 0,  0, 0, 1, 0};
    tv[13] = '{0, 1, 0,  0, 1, 0, 1};
    tv[14] = '{0, 0, 0,  0, 0, 0, 1};
    for (int i = 0; i < 15; i++) begin
      reset  = tv[i].rst;
      ipv[0] = tv[i].v;
      ip[0]  = tv[i].b;
      step();
      chk($sformatf("tv%0d_p", i), 32'(p[0]), 32'(tv[i].ep));
      chk($sformatf("tv%0d_pv", i), 32'(pv[0]), 32'(tv[i].epv));
      chk($sformatf("tv%0d_busy", i), 32'(bsy[0]), 32'(tv[i].ebusy));
      chk($sformatf("tv%0d_fc", i), 32'(fc[0]), 32'(tv[i].efc));
      chk($sformatf("tv%0d_ec", i), 32'(ec[0]), 32'd0);
    end
    reset = 1'b0;
    idle_all();

    // CHECK/even/3 bits: good frame then bad frame, back-to-back.
    send(1, 1); send(1, 0); send(1, 1); send(1, 0);
    chk("chk_good_p", 32'(p[1]), 32'd0);
    chk("chk_good_pv", 32'(pv[1]), 32'd1);
    send(1, 1); send(1, 0); send(1, 1); send(1, 1);
    chk("chk_bad_p", 32'(p[1]), 32'd1);
    chk("chk_bad_pv", 32'(pv[1]), 32'd1);
    chk("chk_ec", 32'(ec[1]), 32'd1);
    chk("chk_fc", 32'(fc[1]), 32'd2);

    // GEN/4 bits with 5-cycle gaps; busy must hold through the gaps.
    send(2, 1);
    for (int g = 0; g < 5; g++) begin step(); chk($sformatf("gap_a%0d_busy", g), 32'(bsy[2]), 32'd1); end
    send(2, 1);
    for (int g = 0; g < 5; g++) begin step(); chk($sformatf("gap_b%0d_busy", g), 32'(bsy[2]), 32'd1); end
    send(2, 1);
    for (int g = 0; g < 5; g++) begin step(); chk($sformatf("gap_c%0d_busy", g), 32'(bsy[2]), 32'd1); end
    send(2, 0);
    chk("gap_p", 32'(p[2]), 32'd0);
    chk("gap_pv", 32'(pv[2]), 32'd1);
    chk("gap_busy_end", 32'(bsy[2]), 32'd0);

    // 2-bit counter saturation after 5 frames, then clear on a completing bit.
    for (int f = 0; f < 4; f++) for (int k = 0; k < 4; k++) send(2, 0);
    chk("sat_fc", 32'(fc[2]), 32'd3);
    chk("sat_p", 32'(p[2]), 32'd1);
    send(2, 0); send(2, 0); send(2, 0);
    clr[2] = 1'b1;
    send(2, 0);
    clr[2] = 1'b0;
    chk("clr_fc", 32'(fc[2]), 32'd0);
    chk("clr_pv", 32'(pv[2]), 32'd1);

    // Single-bit frames: a pulse every cycle, never busy.
    ipv[3] = 1'b1;
    ip[3] = 1'b0; step();
    chk("db1_p0", 32'(p[3]), 32'd1); chk("db1_pv0", 32'(pv[3]), 32'd1); chk("db1_b0", 32'(bsy[3]), 32'd0);
    ip[3] = 1'b1; step();
    chk("db1_p1", 32'(p[3]), 32'd0); chk("db1_pv1", 32'(pv[3]), 32'd1); chk("db1_b1", 32'(bsy[3]), 32'd0);
    ip[3] = 1'b1; step();
    chk("db1_p2", 32'(p[3]), 32'd0); chk("db1_pv2", 32'(pv[3]), 32'd1); chk("db1_b2", 32'(bsy[3]), 32'd0);
    idle_all();
    step();

    // Randomized traffic on all instances.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      for (int d = 0; d < N; d++) begin
        ipv[d] = ($urandom_range(0, 9) < 7);
        ip[d]  = 1'($urandom_range(0, 1));
        clr[d] = ($urandom_range(0, 49) == 0);
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
